// File: rtl/dmem_pkg.sv
// dmem_pkg: shared sizes, FSM states and requester indices for the data-memory arbiter.
package dmem_pkg;
    localparam int DMEM_DEPTH = 256;
    localparam int ADDR_W = $clog2(DMEM_DEPTH);
    localparam int DATA_W = 32;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: winner selection; DMEM_ARB_RR_EN gives round-robin ties, otherwise the CPU wins ties.
module dmem_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any,
    output logic win
);
    import dmem_pkg::*;
    assign any = req0 | req1;
`ifdef DMEM_ARB_RR_EN
    assign win = (req0 && req1) ? ~last_grant : (req1 ? REQ_DMA : REQ_CPU);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign win = req0 ? REQ_CPU : (req1 ? REQ_DMA : REQ_CPU);
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU/DMA word accesses to the data memory; DMEM_ARB_RR_EN enables round-robin ties.
module dmem_arbiter #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_pkg::*;
    state_t state_q, state_d;
    logic any_req, win, last_grant;
    logic sel_we, sel_oor;
    logic [31:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic owner_q, owner_d, we_q, we_d, oor_q, oor_d;
    logic [1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;

    dmem_arb_pick u_pick (
        .req0(req0),
        .req1(req1),
        .last_grant(last_grant),
        .any(any_req),
        .win(win)
    );

    assign sel_we    = win ? we1 : we0;
    assign sel_addr  = win ? addr1 : addr0;
    assign sel_wdata = win ? wdata1 : wdata0;
    assign sel_oor   = |sel_addr[31:ADDR_W];

`ifdef DMEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;
    always_comb last_grant_d = (state_q == IDLE && any_req) ? win : last_grant_q;
    always_ff @(posedge clk) last_grant_q <= rst ? REQ_DMA : last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = REQ_DMA;
`endif

    // Memory-side signals are registered so the memory sees them for the whole ACCESS cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        oor_d       = oor_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: if (any_req) begin
                state_d      = ACCESS;
                owner_d      = win;
                we_d         = sel_we;
                oor_d        = sel_oor;
                gnt_d[win]   = 1'b1;
                mem_addr_d   = sel_addr;
                mem_wdata_d  = sel_wdata;
                mem_read_d   = !sel_we && !sel_oor;
                mem_write_d  = sel_we && !sel_oor;
            end
            ACCESS: begin
                state_d          = DONE;
                done_d[owner_q]  = 1'b1;
                err_d[owner_q]   = oor_q;
                rdata_d[owner_q] = (we_q || oor_q) ? '0 : mem_rdata;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= REQ_CPU;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign gnt0      = gnt_q[REQ_CPU];
    assign gnt1      = gnt_q[REQ_DMA];
    assign done0     = done_q[REQ_CPU];
    assign done1     = done_q[REQ_DMA];
    assign err0      = err_q[REQ_CPU];
    assign err1      = err_q[REQ_DMA];
    assign rdata0    = rdata_q[REQ_CPU];
    assign rdata1    = rdata_q[REQ_DMA];
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, randomized model comparison and multi-cycle corner sequences for dmem_arbiter.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic        win, err;
        logic [31:0] rd;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rd [2];
    logic last_win;
    int compared = 0, mismatched = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] = mem_wdata;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = gnt0 | gnt1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " flags"}, 64'({gnt1, gnt0, done1, done0, err1, err0, mem_read, mem_write}), 64'(0));
        check({tag, " rdata0"}, 64'(rdata0), 64'(0));
        check({tag, " rdata1"}, 64'(rdata1), 64'(0));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    // Reference: tie policy, range rule and a word-array memory image.
    function automatic vec_t model(input vec_t v);
        logic [31:0] a;
        v.win = (v.r0 && v.r1) ? (RR ? !last_win : 1'b0) : v.r1;
        a = v.win ? v.a1 : v.a0;
        v.err = |a[31:8];
        v.rd = ((v.win ? v.w1 : v.w0) || v.err) ? 32'd0 : ref_mem[a[7:0]];
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        bit seen;
        logic w_we;
        logic [31:0] w_a, w_d;
        w_we = v.win ? v.w1 : v.w0;
        w_a = v.win ? v.a1 : v.a0;
        w_d = v.win ? v.d1 : v.d0;
        req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
        addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
        wait_gnt(seen);
        req0 = 1'b0; req1 = 1'b0;
        check({tag, " gnt seen"}, 64'(seen), 64'(1));
        if (seen) begin
            check({tag, " gnt"}, 64'({gnt1, gnt0}), 64'(v.win ? 2'b10 : 2'b01));
            check({tag, " strobes"}, 64'({mem_read, mem_write}), 64'({!w_we && !v.err, w_we && !v.err}));
            check({tag, " mem_addr"}, 64'(mem_addr), 64'(w_a));
            check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(w_d));
            @(negedge clk);
            check({tag, " done"}, 64'({done1, done0}), 64'(v.win ? 2'b10 : 2'b01));
            check({tag, " err"}, 64'({err1, err0}), 64'({v.win && v.err, !v.win && v.err}));
            check({tag, " rdata"}, 64'(v.win ? rdata1 : rdata0), 64'(v.rd));
            check({tag, " rdata hold"}, 64'(v.win ? rdata0 : rdata1), 64'(exp_rd[!v.win]));
            exp_rd[v.win] = v.rd;
            last_win = v.win;
            if (w_we && !v.err) ref_mem[w_a[7:0]] = w_d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_win = 1'b1;
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        bit seen;
        logic any_done;
        int gcyc[$];
        logic gwin[$];
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[255] = 32'h0BADF00D;
        ref_mem[255] = 32'h0BADF00D;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h10, 32'd0, 32'h12345678, 1'b1, 1'b0, 32'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h10, 32'd0, 32'd0, 1'b1, 1'b0, 32'h12345678};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h100, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF0001, 32'd0, 32'h55AA55AA, 32'd0, 1'b0, 1'b1, 32'd0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h12345678};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0BADF00D};

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_win = 1'b1;

        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.r0 = $urandom_range(0, 1) == 1;
            v.r1 = $urandom_range(0, 1) == 1;
            if (!v.r0 && !v.r1) v.r0 = 1'b1;
            v.w0 = $urandom_range(0, 1) == 1;
            v.w1 = $urandom_range(0, 1) == 1;
            v.a0 = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
            v.a1 = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
            v.d0 = $urandom;
            v.d1 = $urandom;
            run(model(v), $sformatf("rand%0d", i));
        end

        // Both requesters held high across four back-to-back accesses.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'd1; addr1 = 32'd2;
        for (int c = 0; c < 14 && gcyc.size() < 4; c++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                gcyc.push_back(c);
                gwin.push_back(gnt1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie grant count", 64'(gcyc.size()), 64'(4));
        for (int i = 0; i < gcyc.size(); i++) begin
            check($sformatf("tie winner%0d", i), 64'(gwin[i]), 64'(RR ? i[0] : 1'b0));
            if (i > 0) check($sformatf("tie spacing%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'(3));
        end
        repeat (3) @(negedge clk);

        // Reset while a write strobe is on the bus.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'hCAFEF00D;
        wait_gnt(seen);
        check("rst gnt0", 64'({seen, gnt0, mem_write}), 64'(3'b111));
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst in access");
        rst = 1'b0;
        ref_mem[7] = 32'hCAFEF00D;
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_win = 1'b1;
        any_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_done = any_done | done0 | done1;
        end
        check("rst no done", 64'(any_done), 64'(0));
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0};
        run(model(v), "post-rst tie");
        check("post-rst winner", 64'(last_win), 64'(0));

        // DMA request arriving while the CPU access is in flight.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'hA5A50F0F;
        wait_gnt(seen);
        check("late gnt0", 64'({seen, gnt0}), 64'(2'b11));
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'd9;
        @(negedge clk);
        check("late done0", 64'({done0, gnt1}), 64'(2'b10));
        @(negedge clk);
        check("late idle", 64'({gnt1, done1}), 64'(2'b00));
        @(negedge clk);
        check("late gnt1", 64'({gnt1, mem_read, mem_addr}), 64'({2'b11, 32'd9}));
        req1 = 1'b0;
        @(negedge clk);
        check("late done1", 64'({done1, err1}), 64'(2'b10));
        check("late rdata1", 64'(rdata1), 64'(32'hA5A50F0F));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
